alu_stateful_v3: RTL and testbench
==================================

Name: alu_stateful_v3

Overview:
- Parametrised successor of the second-type RMT action ALU (add/sub/load/store with a key-value RAM).
- Generalises data width and RAM depth, and partitions the RAM per tenant (VID).
- Adds atomic fetch-and-add, optional saturating arithmetic, and a ready/drop handshake.
- Sits in each stage's action engine and drives one PHV container, with fixed result latency so all ALUs of a stage stay aligned.

Parameters:
- DATA_WIDTH, 32: operand, container and RAM word width.
- ACTION_LEN, 25: action word width; opcode is action_in[ACTION_LEN-1 -: 4].
- VID_W, 4: tenant-ID width; upper RAM address bits.
- SEG_AW, 5: per-tenant address width; lower RAM address bits.
- SATURATE, 0: 1 = unsigned saturating add/sub; 0 = modulo 2^DATA_WIDTH.
- STAGE, 0: stage index, informational only.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- action_in  in  ACTION_LEN  action word
- action_valid  in  1  action and operands valid this cycle
- operand_1_in  in  DATA_WIDTH  operand 1 / store data / FAA increment
- operand_2_in  in  DATA_WIDTH  operand 2 / address source (low SEG_AW bits)
- operand_3_in  in  DATA_WIDTH  pass-through container value
- vid_in  in  VID_W  tenant ID, sampled with action_valid
- alu_ready  out  1  high when idle and able to accept
- container_out  out  DATA_WIDTH  result to PHV
- container_out_valid  out  1  one-cycle result strobe
- action_dropped  out  1  one-cycle pulse when action_valid arrives while busy

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs reset to 0 except alu_ready, which resets to 1.
  - State returns to IDLE; internal regs are cleared.
  - A pending RAM write is cancelled.
  - RAM contents are not reset; simulation init is all-zero.
- RAM: 2^(VID_W+SEG_AW) words of DATA_WIDTH, inferred, one write port and one read port.
  - Synchronous read with 1-cycle latency.
  - addr = {vid_in, operand_2_in[SEG_AW-1:0]}, latched at accept.
  - A tenant can never address outside its own segment.
- Accept: in IDLE, action_valid=1 latches the opcode, operands, vid and addr.
  - If action_valid=1 while not IDLE: the action is ignored and action_dropped pulses that cycle.
- FSM: IDLE -> EXEC -> MEM -> OUT -> IDLE, one cycle per state; no other paths.
  - alu_ready = (state==IDLE).
  - Accept at cycle T gives container_out_valid=1 at exactly T+3 for one cycle, for every opcode.
  - Next accept is possible at T+4.
- Opcodes:
  - 0001 add, 1001 addi: out = op1 + op2.
  - 0010 sub, 1010 subi: out = op1 - op2.
  - 1000 store: write RAM[addr] <= op1 in EXEC; out = op3.
  - 1011 load: read issued in EXEC, data captured in MEM; out = RAM[addr].
  - 0111 fetch-and-add: read in EXEC, capture old in MEM; write RAM[addr] <= old + op1 in MEM; out = old.
  - FAA writes always wrap modulo 2^DATA_WIDTH, independent of SATURATE.
  - Any other opcode: out = op3 (legal no-op). No RAM access.
- Arithmetic:
  - SATURATE=0: results truncated to DATA_WIDTH.
  - SATURATE=1: add carry-out gives all-ones; sub borrow gives 0.
- container_out is 0 whenever container_out_valid=0.
- Hazards:
  - Ops are serialised, so read-after-write to the same address across consecutive actions always sees the new value.
  - Read-during-write inside FAA returns the old value.
- Reset mid-operation: FSM returns to IDLE, no output strobe is produced, and no write occurs if reset was asserted before the write edge.

Test Plan:
- Reset, then addi op1=0xFFFF_FFFF op2=2, SATURATE=0 -> out 0x0000_0001 at T+3. Same with SATURATE=1 -> 0xFFFF_FFFF. sub 3-5, SATURATE=1 -> 0.
- store vid=2 addr=7 op1=0xDEAD_BEEF op3=0x55 -> out 0x55. Then load vid=2 addr=7 -> 0xDEAD_BEEF. Then load vid=3 addr=7 -> 0.
- FAA x3 on vid=1 addr=0, op1=1, starting from 0 -> outs 0, 1, 2. Then load -> 3. Accepts land at T, T+4, T+8.
- action_valid held high 8 cycles with add 1+1 -> two results (T+3, T+7). action_dropped pulses at T+1..T+3 and T+5..T+7. alu_ready low in those cycles.
- Opcode 0000 op3=0x1234 -> out 0x1234 at T+3, RAM unchanged. Check container_out=0 in every non-valid cycle.
- Assert rst_n low at T+1 of an FAA on addr 4 holding 9 -> no valid strobe, alu_ready=1. Subsequent load addr 4 -> 9.

Source files
------------

// File: rtl/alu_stateful_v3.sv
// rtl/alu_stateful_v3.sv - stateful action ALU with per-tenant key-value RAM
// Fixed 3-cycle result latency: IDLE -> EXEC -> MEM -> OUT for every opcode.
module alu_stateful_v3 #(
  parameter int DATA_WIDTH = 32,
  parameter int ACTION_LEN = 25,
  parameter int VID_W      = 4,
  parameter int SEG_AW     = 5,
  parameter int SATURATE   = 0,
  parameter int STAGE      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid,
  input  logic [DATA_WIDTH-1:0] operand_1_in,
  input  logic [DATA_WIDTH-1:0] operand_2_in,
  input  logic [DATA_WIDTH-1:0] operand_3_in,
  input  logic [VID_W-1:0]      vid_in,
  output logic                  alu_ready,
  output logic [DATA_WIDTH-1:0] container_out,
  output logic                  container_out_valid,
  output logic                  action_dropped
);
  localparam int AW    = VID_W + SEG_AW;
  localparam int DEPTH = 1 << AW;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1011;
  localparam logic [3:0] OP_FAA   = 4'b0111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_OUT} state_t;

  state_t                state_q;
  logic [3:0]            opcode_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, op3_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  valid_q;
  logic                  ready_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH:0]   sum_w, diff_w;
  logic [DATA_WIDTH-1:0] add_res, sub_res, result_d, ram_wdata;
  logic                  ram_we;

  logic unused_bits;
  assign unused_bits = ^{action_in[ACTION_LEN-5:0], (STAGE != 0)};

  always_comb begin
    sum_w    = {1'b0, op1_q} + {1'b0, op2_q};
    diff_w   = {1'b0, op1_q} - {1'b0, op2_q};
    add_res  = ((SATURATE != 0) && sum_w[DATA_WIDTH])  ? '1 : sum_w[DATA_WIDTH-1:0];
    sub_res  = ((SATURATE != 0) && diff_w[DATA_WIDTH]) ? '0 : diff_w[DATA_WIDTH-1:0];
    result_d = op3_q;
    case (opcode_q)
      OP_ADD, OP_ADDI: result_d = add_res;
      OP_SUB, OP_SUBI: result_d = sub_res;
      OP_LOAD, OP_FAA: result_d = rd_q;
      default:         result_d = op3_q;
    endcase
    // FAA increment always wraps, whatever the saturation mode
    ram_we    = ((state_q == S_EXEC) && (opcode_q == OP_STORE)) ||
                ((state_q == S_MEM)  && (opcode_q == OP_FAA));
    ram_wdata = (opcode_q == OP_FAA) ? (rd_q + op1_q) : op1_q;
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[addr_q] <= ram_wdata;
    end
    if (state_q == S_EXEC) begin
      rd_q <= mem_q[addr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      op3_q    <= '0;
      addr_q   <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (action_valid) begin
            opcode_q <= action_in[ACTION_LEN-1 -: 4];
            op1_q    <= operand_1_in;
            op2_q    <= operand_2_in;
            op3_q    <= operand_3_in;
            addr_q   <= {vid_in, operand_2_in[SEG_AW-1:0]};
            ready_q  <= 1'b0;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: state_q <= S_MEM;
        S_MEM: begin
          out_q   <= result_d;
          valid_q <= 1'b1;
          state_q <= S_OUT;
        end
        default: begin
          out_q   <= '0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_ready           = ready_q;
  assign container_out       = out_q;
  assign container_out_valid = valid_q;
  assign action_dropped      = action_valid && !ready_q;

endmodule

// File: tb/tb_alu_stateful_v3.sv
// tb/tb_alu_stateful_v3.sv - scoreboard bench for alu_stateful_v3
// Runs a wrapping and a saturating instance side by side on the same stimulus.
module tb_alu_stateful_v3;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [24:0] action_in = '0;
  logic        action_valid = 1'b0;
  logic [31:0] operand_1_in = '0, operand_2_in = '0, operand_3_in = '0;
  logic [3:0]  vid_in = '0;

  logic        rdy0, rdy1, val0, val1, drop0, drop1;
  logic [31:0] out0, out1;

  alu_stateful_v3 #(.SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(action_valid),
    .operand_1_in(operand_1_in), .operand_2_in(operand_2_in), .operand_3_in(operand_3_in),
    .vid_in(vid_in), .alu_ready(rdy0), .container_out(out0),
    .container_out_valid(val0), .action_dropped(drop0));

  alu_stateful_v3 #(.SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(action_valid),
    .operand_1_in(operand_1_in), .operand_2_in(operand_2_in), .operand_3_in(operand_3_in),
    .vid_in(vid_in), .alu_ready(rdy1), .container_out(out1),
    .container_out_valid(val1), .action_dropped(drop1));

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] r0;
    logic [31:0] r1;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model_mem [512];
  int          cyc = 0;
  int          next_free = 0;
  bit          exp_ready = 1'b1;
  bit          exp_drop = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the model decides accept/drop from the one-op-per-4-cycles rule.
  task automatic drive(input bit v, input logic [3:0] op, input logic [3:0] vid,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [8:0]  addr;
    logic [32:0] s;
    exp_t        e;
    @(posedge clk);
    #1;
    action_valid = v;
    action_in    = {op, 21'($urandom)};
    vid_in       = vid;
    operand_1_in = a;
    operand_2_in = b;
    operand_3_in = c;
    exp_ready    = (cyc >= next_free);
    exp_drop     = v && (cyc < next_free);
    if (v && cyc >= next_free) begin
      addr  = {vid, b[4:0]};
      e.due = cyc + 3;
      case (op)
        4'b0001, 4'b1001: begin
          s    = {1'b0, a} + {1'b0, b};
          e.r0 = s[31:0];
          e.r1 = s[32] ? 32'hFFFF_FFFF : s[31:0];
        end
        4'b0010, 4'b1010: begin
          e.r0 = a - b;
          e.r1 = (a < b) ? 32'h0 : a - b;
        end
        4'b1000: begin
          model_mem[addr] = a;
          e.r0 = c;
          e.r1 = c;
        end
        4'b1011: begin
          e.r0 = model_mem[addr];
          e.r1 = model_mem[addr];
        end
        4'b0111: begin
          e.r0 = model_mem[addr];
          e.r1 = model_mem[addr];
          model_mem[addr] = model_mem[addr] + a;
        end
        default: begin
          e.r0 = c;
          e.r1 = c;
        end
      endcase
      sbq.push_back(e);
      next_free = cyc + 4;
    end
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [3:0] vid,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    drive(1'b1, op, vid, a, b, c);
    repeat (3) idle();
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    check(rdy0 == exp_ready && rdy1 == exp_ready, "alu_ready", {30'b0, rdy1, rdy0}, {31'b0, exp_ready});
    check(drop0 == exp_drop && drop1 == exp_drop, "action_dropped", {30'b0, drop1, drop0}, {31'b0, exp_drop});
    if (val0 || val1) begin
      if (sbq.size() == 0) begin
        check(1'b0, "unexpected_valid", {30'b0, val1, val0}, 32'h0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check(cyc == e.due, "latency", cyc, e.due);
        check(val0 && val1, "valid_pair", {30'b0, val1, val0}, 32'h3);
        check(out0 == e.r0, "out_wrap", out0, e.r0);
        check(out1 == e.r1, "out_sat", out1, e.r1);
      end
    end else begin
      check(out0 == 32'h0 && out1 == 32'h0, "out_zero_when_idle", out0 | out1, 32'h0);
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        check(1'b0, "missing_valid", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] saved;
    logic [3:0]  ops [8];
    logic [31:0] b;
    ops = '{4'b0001, 4'b1001, 4'b0010, 4'b1010, 4'b1000, 4'b1011, 4'b0111, 4'b0000};
    foreach (model_mem[i]) model_mem[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(4'b1001, 4'd0, 32'hFFFF_FFFF, 32'd2, 32'h0);
    do_op(4'b0010, 4'd0, 32'd3, 32'd5, 32'h0);

    do_op(4'b1000, 4'd2, 32'hDEAD_BEEF, 32'd7, 32'h55);
    do_op(4'b1011, 4'd2, 32'h0, 32'd7, 32'h0);
    do_op(4'b1011, 4'd3, 32'h0, 32'd7, 32'h0);

    repeat (3) do_op(4'b0111, 4'd1, 32'd1, 32'd0, 32'h0);
    do_op(4'b1011, 4'd1, 32'h0, 32'd0, 32'h0);

    repeat (8) drive(1'b1, 4'b0001, 4'd0, 32'd1, 32'd1, 32'h0);
    repeat (3) idle();

    do_op(4'b0000, 4'd2, 32'hAAAA_0000, 32'd7, 32'h1234);
    do_op(4'b1011, 4'd2, 32'h0, 32'd7, 32'h0);

    // Reset lands during EXEC of an FAA: no strobe, no write
    do_op(4'b1000, 4'd0, 32'd9, 32'd4, 32'h0);
    saved = model_mem[9'd4];
    drive(1'b1, 4'b0111, 4'd0, 32'd5, 32'd4, 32'h0);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    action_valid = 1'b0;
    exp_ready    = 1'b1;
    exp_drop     = 1'b0;
    sbq.delete();
    model_mem[9'd4] = saved;
    next_free    = 0;
    idle();
    idle();
    rst_n = 1'b1;
    do_op(4'b1011, 4'd0, 32'h0, 32'd4, 32'h0);

    for (int i = 0; i < 600; i++) begin
      b = ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(0, 3));
      drive($urandom_range(0, 2) != 0,
            ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)],
            4'($urandom_range(0, 3)), pick_val(), ($urandom_range(0, 1) != 0) ? b : pick_val(),
            $urandom);
    end
    repeat (6) idle();
    check(sbq.size() == 0, "scoreboard_drained", sbq.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
